// File: rtl/fft_unload.sv
// fft_unload: output stage behind the FFT reorder network.
// Captures one packed frame (LEN complex samples) per handshake into a
// two-bank ping-pong buffer. Streams each frame out one sample per cycle
// with valid/ready backpressure, a bin index and a last-sample flag.
// The next frame can be accepted while the current one drains.
//
// Build option: define FFT_UNLOAD_BITREV_EN to read samples from address
// bitrev(cnt), so that a frame stored in bit-reversed order leaves in
// natural bin order. In that build dout_idx_o reports bitrev(cnt).
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   frame_val_i / frame_rdy_o     frame handshake (rdy independent of val)
//   fft_data_re_i/fft_data_im_i   packed frame, sample n at [n*DW +: DW]
//   dout_val_o / dout_rdy_i       sample handshake
//   dout_re_o, dout_im_o          current sample (0 while empty)
//   dout_idx_o                    bin index of current sample
//   dout_last_o                   current sample ends its frame
//   busy_o                        at least one frame is held

`ifndef FFT_LEN
`define FFT_LEN 8
`endif
`ifndef DATA_WID
`define DATA_WID 16
`endif
`ifndef LOG2_FFT_LEN
`define LOG2_FFT_LEN 3
`endif

module fft_unload #(
    parameter int unsigned LEN = `FFT_LEN,
    parameter int unsigned DW  = `DATA_WID,
    parameter int unsigned AW  = `LOG2_FFT_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_val_i,
    output logic              frame_rdy_o,
    input  logic [LEN*DW-1:0] fft_data_re_i,
    input  logic [LEN*DW-1:0] fft_data_im_i,
    output logic              dout_val_o,
    input  logic              dout_rdy_i,
    output logic [DW-1:0]     dout_re_o,
    output logic [DW-1:0]     dout_im_o,
    output logic [AW-1:0]     dout_idx_o,
    output logic              dout_last_o,
    output logic              busy_o
);

    localparam logic [AW-1:0] CNT_MAX = AW'(LEN - 1);

    logic [DW-1:0] bank_re [2][LEN];
    logic [DW-1:0] bank_im [2][LEN];

    logic          wr_sel, wr_sel_nxt;
    logic          rd_sel, rd_sel_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [1:0]    nfrm, nfrm_nxt;

    logic          acc, pop, done;
    logic [AW-1:0] addr;

`ifdef FFT_UNLOAD_BITREV_EN
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(AW); i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction
`endif

    // Handshakes, read address and output gating
    always_comb begin
        frame_rdy_o = (nfrm != 2'd2);
        dout_val_o  = (nfrm != 2'd0);
        busy_o      = (nfrm != 2'd0);
        acc         = frame_val_i & frame_rdy_o;
        pop         = dout_val_o & dout_rdy_i;
        done        = pop & (cnt == CNT_MAX);
`ifdef FFT_UNLOAD_BITREV_EN
        addr        = bitrev(cnt);
`else
        addr        = cnt;
`endif
        dout_last_o = dout_val_o & (cnt == CNT_MAX);
        // Bank contents are never reset, so data is forced to 0 while empty
        dout_re_o   = dout_val_o ? bank_re[rd_sel][addr] : '0;
        dout_im_o   = dout_val_o ? bank_im[rd_sel][addr] : '0;
        dout_idx_o  = dout_val_o ? addr : '0;
    end

    // Next-state for pointers, sample counter and frame occupancy
    always_comb begin
        wr_sel_nxt = wr_sel;
        rd_sel_nxt = rd_sel;
        cnt_nxt    = cnt;
        nfrm_nxt   = nfrm;
        if (acc) begin
            wr_sel_nxt = ~wr_sel;
        end
        if (pop) begin
            cnt_nxt = done ? '0 : cnt + AW'(1);
        end
        if (done) begin
            rd_sel_nxt = ~rd_sel;
        end
        case ({acc, done})
            2'b10:   nfrm_nxt = nfrm + 2'd1;
            2'b01:   nfrm_nxt = nfrm - 2'd1;
            default: nfrm_nxt = nfrm;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            cnt    <= '0;
            nfrm   <= 2'd0;
        end else begin
            wr_sel <= wr_sel_nxt;
            rd_sel <= rd_sel_nxt;
            cnt    <= cnt_nxt;
            nfrm   <= nfrm_nxt;
        end
    end

    // Frame capture into the write bank (storage only, no reset)
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int n = 0; n < int'(LEN); n++) begin
                bank_re[wr_sel][n] <= fft_data_re_i[n*DW +: DW];
                bank_im[wr_sel][n] <= fft_data_im_i[n*DW +: DW];
            end
        end
    end

endmodule
